// File: rtl/fir_moving_average.sv
// Streaming 2^LOG2_TAPS-tap moving-average filter over signed 8-bit samples.
// Optional round-half-up before the shift when FIR_MAVG_ROUND_EN is defined.
module fir_moving_average #(
    parameter int unsigned LOG2_TAPS = 2,
    parameter int unsigned COUNT_W   = 36
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     sample_valid,
    input  logic signed [7:0]        sample_in,
    output logic signed [7:0]        avg_out,
    output logic                     avg_valid,
    output logic                     primed,
    output logic [COUNT_W-1:0]       sample_count
);

    localparam int unsigned N  = 1 << LOG2_TAPS;
    localparam int unsigned SW = 8 + LOG2_TAPS;
    localparam logic [LOG2_TAPS:0] FillFull = (LOG2_TAPS + 1)'(N);

    logic signed [7:0]     win_q [N];
    logic [LOG2_TAPS-1:0]  wp_q;
    logic signed [SW-1:0]  sum_q, sum_d;
    logic signed [SW-1:0]  sample_ext, oldest_ext;
    logic [LOG2_TAPS:0]    fill_q;
    logic                  enable_q;
    logic signed [7:0]     avg_q, avg_d;
    logic                  avg_valid_q;
    logic [COUNT_W-1:0]    count_q;
    logic                  clear, accept;

    // A rising edge of enable restarts the filter and drops any coincident sample.
    assign clear  = enable & ~enable_q;
    assign accept = sample_valid & enable & ~clear;

    assign sample_ext = {{LOG2_TAPS{sample_in[7]}}, sample_in};
    assign oldest_ext = {{LOG2_TAPS{win_q[wp_q][7]}}, win_q[wp_q]};
    assign sum_d      = sum_q + sample_ext - oldest_ext;

`ifdef FIR_MAVG_ROUND_EN
    localparam logic [SW:0] RndBias = (SW + 1)'(1) << (LOG2_TAPS - 1);
    logic signed [SW:0] sum_rnd;
    assign sum_rnd = {sum_d[SW-1], sum_d} + RndBias;
    assign avg_d   = 8'(sum_rnd >>> LOG2_TAPS);
`else
    assign avg_d   = 8'(sum_d >>> LOG2_TAPS);
`endif

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            enable_q <= 1'b0;
        end else begin
            enable_q <= enable;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset || clear) begin
            for (int i = 0; i < int'(N); i++) begin
                win_q[i] <= '0;
            end
            wp_q        <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            count_q     <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else if (accept) begin
            win_q[wp_q] <= sample_in;
            wp_q        <= wp_q + LOG2_TAPS'(1);
            sum_q       <= sum_d;
            count_q     <= count_q + COUNT_W'(1);
            avg_q       <= avg_d;
            avg_valid_q <= 1'b1;
            if (fill_q != FillFull) begin
                fill_q <= fill_q + (LOG2_TAPS + 1)'(1);
            end
        end else begin
            avg_valid_q <= 1'b0;
        end
    end

    assign avg_out      = avg_q;
    assign avg_valid    = avg_valid_q;
    assign primed       = (fill_q == FillFull);
    assign sample_count = count_q;

endmodule

// File: tb/tb_fir_moving_average.sv
// Self-checking bench for fir_moving_average: queue-based window model plus
// directed scenarios and randomized traffic on a 36-bit and a 4-bit counter build.
module tb_fir_moving_average;

    localparam int N = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    logic              sample_valid = 1'b0;
    logic signed [7:0] sample_in = '0;

    logic signed [7:0] avg_out, avg_out_w;
    logic              avg_valid, avg_valid_w;
    logic              primed, primed_w;
    logic [35:0]       sample_count;
    logic [3:0]        sample_count_w;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fir_moving_average #(.LOG2_TAPS(2), .COUNT_W(36)) dut (
        .CLOCK_50(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample_in(sample_in), .avg_out(avg_out), .avg_valid(avg_valid),
        .primed(primed), .sample_count(sample_count)
    );

    fir_moving_average #(.LOG2_TAPS(2), .COUNT_W(4)) dut_w (
        .CLOCK_50(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
        .sample_in(sample_in), .avg_out(avg_out_w), .avg_valid(avg_valid_w),
        .primed(primed_w), .sample_count(sample_count_w)
    );

    // Model: window of the last N accepted samples (zero-filled), exact floor division.
    int     win[$];
    int     fill;
    longint exp_count;
    int     exp_avg;
    bit     exp_valid;
    bit     m_en_q;

    function automatic int floor_div(input int a);
        int q = a / N;
        if ((a % N != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic void model_clear();
        win.delete();
        for (int i = 0; i < N; i++) win.push_back(0);
        fill = 0;
        exp_count = 0;
        exp_avg = 0;
        exp_valid = 1'b0;
    endfunction

    always @(posedge clk) begin
        int s;
        if (reset) begin
            model_clear();
            m_en_q = 1'b0;
        end else if (enable && !m_en_q) begin
            model_clear();
            m_en_q = 1'b1;
        end else begin
            m_en_q = enable;
            if (enable && sample_valid) begin
                void'(win.pop_front());
                win.push_back(int'(sample_in));
                s = 0;
                foreach (win[i]) s += win[i];
`ifdef FIR_MAVG_ROUND_EN
                exp_avg = floor_div(s + N / 2);
`else
                exp_avg = floor_div(s);
`endif
                exp_valid = 1'b1;
                exp_count++;
                if (fill < N) fill++;
            end else begin
                exp_valid = 1'b0;
            end
        end
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("avg_out", int'(avg_out), exp_avg);
            check("avg_valid", avg_valid, exp_valid);
            check("primed", primed, fill >= N);
            check("count36", sample_count, exp_count & 64'hF_FFFF_FFFF);
            check("avg_out_w", int'(avg_out_w), exp_avg);
            check("avg_valid_w", avg_valid_w, exp_valid);
            check("primed_w", primed_w, fill >= N);
            check("count4", sample_count_w, exp_count & 64'hF);
        end
    end

    task automatic feed(input int s);
        sample_valid = 1'b1;
        sample_in = 8'(s);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    // Pulse reset, then spend one cycle on the enable rising-edge clear.
    task automatic restart();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int warm_in[5]  = '{4, 8, 12, 16, 20};
        int warm_exp[5] = '{1, 3, 6, 10, 14};
`ifdef FIR_MAVG_ROUND_EN
        int neg_exp[4] = '{0, 0, -1, -1};
`else
        int neg_exp[4] = '{-1, -1, -1, -1};
`endif
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_avg", int'(avg_out), 0);
        check("rst_valid", avg_valid, 0);
        check("rst_primed", primed, 0);
        check("rst_count", sample_count, 0);

        reset = 1'b0;
        enable = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            feed(warm_in[i]);
            check("warm_avg", int'(avg_out), warm_exp[i]);
            check("warm_primed", primed, i >= 3);
        end
        check("warm_count", sample_count, 5);

        // Reset one cycle after an accept.
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_avg", int'(avg_out), 0);
        check("midrst_valid", avg_valid, 0);
        check("midrst_primed", primed, 0);
        check("midrst_count", sample_count, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        feed(4);
        check("midrst_after", int'(avg_out), 1);

        restart();
        for (int i = 0; i < 4; i++) begin
            feed(-1);
            check("neg_avg", int'(avg_out), neg_exp[i]);
        end

        restart();
        repeat (4) feed(127);
        check("max_avg", int'(avg_out), 127);
        repeat (4) feed(-128);
        check("min_avg", int'(avg_out), -128);

        // Enable gating and restart-on-rise.
        restart();
        feed(10);
        feed(20);
        enable = 1'b0;
        sample_valid = 1'b1;
        sample_in = 8'sd99;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("gate_valid", avg_valid, 0);
            check("gate_hold", int'(avg_out), exp_avg);
            check("gate_count", sample_count, 2);
        end
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("rise_valid", avg_valid, 0);
        check("rise_avg", int'(avg_out), 0);
        check("rise_count", sample_count, 0);
        feed(8);
        check("rise_next_avg", int'(avg_out), 2);
        check("rise_next_count", sample_count, 1);

        // Counter wrap on the 4-bit build.
        enable = 1'b0;
        @(posedge clk);
        #1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            feed(int'($urandom_range(255)) - 128);
            check("wrap_valid", avg_valid_w, 1);
        end
        check("wrap_count4", sample_count_w, 0);
        check("wrap_count36", sample_count, 16);
        check("wrap_primed", primed_w, 1);

        // Randomized traffic, checked by the compare process.
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 6) enable = ~enable;
            sample_valid = ($urandom_range(99) < 75);
            sample_in = 8'($urandom);
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        sample_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
